toggle_bank_ctrl: RTL

- Owns a bank of NCELL one-bit Moore toggle cells. Each cell's output equals its registered state, and a cell toggles on a clock edge when its toggle enable is 1.
- Shares that bank among NREQ requesters through a round-robin arbiter.
- A granted requester names one cell and a toggle count. The controller sequences exactly that many toggle cycles on the cell, then signals completion.
- Sits between software-visible command sources and the FSM cell bank; it is the only writer of the cells.

---
 rtl/toggle_bank_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/toggle_bank_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/toggle_bank_pkg.sv
// Shared types and helpers for the toggle bank controller.
package toggle_bank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NREQ_DEF  = 4;
  localparam int NCELL_DEF = 8;
  localparam int CNT_W_DEF = 4;

  function automatic logic cell_in_range(input int idx, input int ncell);
    return idx < ncell;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans upward from last_grant+1 with wrap.
module rr_arbiter
  import toggle_bank_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  // Walk the ring from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    logic [IW-1:0] j;
    grant = '0;
    idx   = '0;
    j     = '0;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(last_grant) + k) % N);
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/toggle_bank_ctrl.sv
// Arbitrated sequencer that toggles one cell of a registered bank N times per request.
module toggle_bank_ctrl
  import toggle_bank_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int NCELL  = NCELL_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int CELL_W = (NCELL > 1) ? $clog2(NCELL) : 1,
  localparam int REQ_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*CELL_W-1:0]  req_cell,
  input  logic [NREQ*CNT_W-1:0]   req_count,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         done,
  output logic                    err,
  input  logic                    clr,
  output logic                    abort,
  output logic                    busy,
  output logic [NCELL-1:0]        state_z
);

  state_t            state, state_n;
  logic [REQ_W-1:0]  cur_req, cur_req_n, last_grant, last_grant_n, gidx;
  logic [CELL_W-1:0] cur_cell, cur_cell_n, sel_cell;
  logic [CNT_W-1:0]  remaining, remaining_n, sel_count;
  logic [NREQ-1:0]   grant;
  logic [NCELL-1:0]  toggle_en;
  logic              run_act, done_act;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .idx        (gidx)
  );

  assign sel_cell  = req_cell[int'(gidx)*CELL_W +: CELL_W];
  assign sel_count = req_count[int'(gidx)*CNT_W +: CNT_W];
  assign run_act   = (state == RUN) && !clr;
  assign done_act  = (state == DONE) && !clr;

  // Reset gates the accept strobe so nothing is granted while the bank is held.
  assign req_ready = (reset && state == IDLE && !clr) ? grant : '0;
  assign err       = done_act && !cell_in_range(int'(cur_cell), NCELL);
  assign abort     = (state == RUN) && clr;
  assign busy      = (state != IDLE);

  always_comb begin
    done = '0;
    if (done_act) done[cur_req] = 1'b1;
  end

  always_comb begin
    toggle_en = '0;
    for (int c = 0; c < NCELL; c++) begin
      toggle_en[c] = run_act && (int'(cur_cell) == c);
    end
  end

  always_comb begin
    state_n      = state;
    cur_req_n    = cur_req;
    cur_cell_n   = cur_cell;
    remaining_n  = remaining;
    last_grant_n = last_grant;
    if (clr) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            cur_req_n   = gidx;
            cur_cell_n  = sel_cell;
            remaining_n = sel_count;
            state_n     = (sel_count == '0 || !cell_in_range(int'(sel_cell), NCELL)) ? DONE : RUN;
          end
        end
        RUN: begin
          remaining_n = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) state_n = DONE;
        end
        DONE: begin
          last_grant_n = cur_req;
          state_n      = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cur_req    <= '0;
      cur_cell   <= '0;
      remaining  <= '0;
      last_grant <= REQ_W'(NREQ - 1);
      state_z    <= '0;
    end else begin
      state      <= state_n;
      cur_req    <= cur_req_n;
      cur_cell   <= cur_cell_n;
      remaining  <= remaining_n;
      last_grant <= last_grant_n;
      state_z    <= clr ? '0 : (state_z ^ toggle_en);
    end
  end

endmodule
